// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : router_pkg
//  Brief    : Shared FSM state type, header field helpers and address width.
//  Revision : 1.0
// ============================================================================
package router_pkg;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_EMPTY = 3'd1,
        S_LOAD       = 3'd2,
        S_CHECK      = 3'd3,
        S_DROP       = 3'd4
    } state_t;

    // Address field is never narrower than one bit, even for two ports.
    function automatic int calc_aw(input int nports);
        int aw;
        aw = 1;
        while ((1 << aw) < nports) aw++;
        return aw;
    endfunction

    function automatic int unsigned hdr_addr(input int unsigned word, input int unsigned aw);
        return word & ((32'd1 << aw) - 32'd1);
    endfunction

    function automatic int unsigned hdr_len(input int unsigned word, input int unsigned aw);
        return word >> aw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/router_nport_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : router_nport_fifo
//  Brief    : Per-port FIFO with registered read data and synchronous flush.
//  Revision : 1.0
// ============================================================================
module router_nport_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_empty,
    output logic             o_full
);

    localparam int c_pw = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_pw-1:0]  r_wr_ptr;
    logic [c_pw-1:0]  r_rd_ptr;
    logic [WIDTH-1:0] r_rd_data;
    logic [c_pw-1:0]  w_count;
    logic             w_do_wr;
    logic             w_do_rd;

    assign w_count   = r_wr_ptr - r_rd_ptr;
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (w_count == c_pw'(DEPTH));
    assign w_do_wr   = i_wr_en && !i_flush && !o_full;
    assign w_do_rd   = i_rd_en && !i_flush && !o_empty;
    assign o_rd_data = r_rd_data;

    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr[c_pw-2:0]] <= i_wr_data;
        end
    end

    // Flush returns both pointers to zero; the last read word stays visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_rd_data <= '0;
        end else if (i_flush) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_rd) begin
                r_rd_data <= r_mem[r_rd_ptr[c_pw-2:0]];
                r_rd_ptr  <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/router_nport.sv
`default_nettype none
// ============================================================================
//  Module   : router_nport
//  Brief    : Packet router, one source to NPORTS parity-checked port FIFOs.
//  Revision : 1.0
// ============================================================================
module router_nport
    import router_pkg::*;
#(
    parameter int NPORTS  = 3,
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 30
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    pkt_valid,
    input  logic [WIDTH-1:0]        data_in,
    input  logic [NPORTS-1:0]       read_enb,
    output logic [NPORTS*WIDTH-1:0] data_out,
    output logic [NPORTS-1:0]       valid_out,
    output logic                    busy,
    output logic                    error,
    output logic                    drop
);

    localparam int          c_aw     = calc_aw(NPORTS);
    localparam int          c_lw     = WIDTH - c_aw;
    localparam int          c_tw     = $clog2(TIMEOUT + 1);
    localparam logic [31:0] c_nports = NPORTS;

    state_t            r_state;
    logic [c_aw-1:0]   r_dest;
    logic [WIDTH-1:0]  r_hdr;
    logic [c_lw-1:0]   r_len;
    logic [c_lw-1:0]   r_cnt;
    logic [WIDTH-1:0]  r_parity;
    logic              r_par_bad;
    logic              r_error;
    logic              r_drop;

    logic [c_aw-1:0]   w_addr;
    logic [c_lw-1:0]   w_len;
    logic              w_bad;
    logic [NPORTS-1:0] w_empty;
    logic [NPORTS-1:0] w_full;
    logic [NPORTS-1:0] w_flush;
    logic              w_wr;
    logic [c_aw-1:0]   w_wr_port;
    logic [WIDTH-1:0]  w_wr_data;
    logic              w_busy;

    assign w_addr    = c_aw'(hdr_addr(32'(data_in), c_aw));
    assign w_len     = c_lw'(hdr_len(32'(data_in), c_aw));
    assign w_bad     = ({{(32-c_aw){1'b0}}, w_addr} >= c_nports) || (w_len == '0);
    assign w_wr_port = (r_state == S_IDLE) ? w_addr : r_dest;
    assign w_wr_data = (r_state == S_WAIT_EMPTY) ? r_hdr : data_in;
    assign valid_out = ~w_empty;
    assign busy      = w_busy;
    assign error     = r_error;
    assign drop      = r_drop;

    always_comb begin
        w_wr   = 1'b0;
        w_busy = 1'b0;
        case (r_state)
            S_IDLE:       w_wr = pkt_valid && !w_bad && w_empty[w_addr];
            S_WAIT_EMPTY: begin
                w_wr   = w_empty[r_dest];
                w_busy = 1'b1;
            end
            S_LOAD: begin
                w_wr   = !w_flush[r_dest] && !w_full[r_dest];
                w_busy = w_full[r_dest];
            end
            S_CHECK:      w_busy = 1'b1;
            default:      w_busy = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_dest    <= '0;
            r_hdr     <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_parity  <= '0;
            r_par_bad <= 1'b0;
            r_error   <= 1'b0;
            r_drop    <= 1'b0;
        end else begin
            r_drop <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (pkt_valid) begin
                        r_error  <= 1'b0;
                        r_dest   <= w_addr;
                        r_hdr    <= data_in;
                        r_len    <= w_len;
                        r_cnt    <= '0;
                        r_parity <= data_in;
                        if (w_bad) begin
                            r_state <= S_DROP;
                            r_drop  <= 1'b1;
                        end else if (w_empty[w_addr]) begin
                            r_state <= S_LOAD;
                        end else begin
                            r_state <= S_WAIT_EMPTY;
                        end
                    end
                end
                S_WAIT_EMPTY: begin
                    if (w_empty[r_dest]) r_state <= S_LOAD;
                end
                S_LOAD: begin
                    // A flushed destination loses the packet; a parity word
                    // arriving in the same cycle ends it outright.
                    if (w_flush[r_dest]) begin
                        r_state <= pkt_valid ? S_DROP : S_IDLE;
                        r_drop  <= 1'b1;
                    end else if (!w_full[r_dest]) begin
                        if (pkt_valid) begin
                            r_parity <= r_parity ^ data_in;
                            if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
                        end else begin
                            r_par_bad <= (data_in != r_parity);
                            r_state   <= S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    r_error <= r_par_bad || (r_cnt != r_len);
                    r_state <= S_IDLE;
                end
                S_DROP: begin
                    if (!pkt_valid) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < NPORTS; i++) begin : g_port
        logic [c_tw-1:0] r_to_cnt;
        logic            w_wr_en;

        assign w_wr_en    = w_wr && (w_wr_port == c_aw'(i));
        assign w_flush[i] = (r_to_cnt == c_tw'(TIMEOUT));

        always_ff @(posedge clock) begin
            if (reset) begin
                r_to_cnt <= '0;
            end else if (w_flush[i] || w_empty[i] || read_enb[i]) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
        end

        router_nport_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk       (clock),
            .rst       (reset),
            .i_wr_en   (w_wr_en),
            .i_wr_data (w_wr_data),
            .i_rd_en   (read_enb[i]),
            .i_flush   (w_flush[i]),
            .o_rd_data (data_out[i*WIDTH +: WIDTH]),
            .o_empty   (w_empty[i]),
            .o_full    (w_full[i])
        );
    end

endmodule
`default_nettype wire

// File: doc/router_nport.md
ROUTER_NPORT -- requirements
Module: router_nport

Interface
REQ-001 Parameter NPORTS, default 3: output port count, 2..8.
REQ-002 Parameter WIDTH, default 8: data word width, >= AW+2.
REQ-003 Parameter DEPTH, default 16: words per port FIFO, power of two.
REQ-004 Parameter TIMEOUT, default 30: unread cycles before a port is flushed.
REQ-005 clock  in  1  single clock; all logic on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 pkt_valid  in  1  high for header and payload words; low on the parity word.
REQ-008 data_in  in  WIDTH  packet word from source.
REQ-009 read_enb  in  NPORTS  per-port pop request.
REQ-010 data_out  out  NPORTS*WIDTH  per-port read data; port i at bits [i*WIDTH +: WIDTH].
REQ-011 valid_out  out  NPORTS  port i FIFO non-empty.
REQ-012 busy  out  1  source holds data_in/pkt_valid this cycle.
REQ-013 error  out  1  last packet had a parity or length mismatch.
REQ-014 drop  out  1  one-cycle pulse: packet discarded.

Function
REQ-015 AW = max(1, clog2(NPORTS)); header addr = data_in[AW-1:0], length = data_in[WIDTH-1:AW].
REQ-016 FSM states: IDLE, WAIT_EMPTY, LOAD, CHECK, DROP.
REQ-017 IDLE (busy 0): on pkt_valid=1, header sampled; addr>=NPORTS or length==0 -> DROP with drop pulse; destination FIFO empty -> header written, LOAD; else header held, WAIT_EMPTY.
REQ-018 WAIT_EMPTY: busy 1; on destination empty, held header written, -> LOAD.
REQ-019 LOAD: busy = destination full; when not busy, each pkt_valid=1 word is written and XORed into running parity (header included), and payload counter increments.
REQ-020 LOAD: first pkt_valid=0 cycle with destination not full: parity word written to FIFO and compared, -> CHECK; if full, busy 1 and word held.
REQ-021 CHECK: busy 1 for exactly one cycle; error <= (parity mismatch) or (payload count != length); -> IDLE.
REQ-022 error holds its value until next header accepted in IDLE, then clears.
REQ-023 DROP: busy 0; words consumed, not stored; first pkt_valid=0 word consumed, -> IDLE.
REQ-024 FIFO: write/read simultaneous allowed incl. full and empty; read of empty ignored; write when full impossible (busy).
REQ-025 data_out[i] registered: updates the cycle after read_enb[i] with FIFO non-empty; otherwise holds.
REQ-026 valid_out[i] = ~empty[i], no latency beyond FIFO pointer update.
REQ-027 Timeout: per port, counter counts cycles with valid_out=1 and read_enb=0; reset by any read or empty; on reaching TIMEOUT, FIFO i flushed next cycle and counter cleared.
REQ-028 Flush of current LOAD destination aborts packet: -> DROP, drop pulse; remaining words discarded.
REQ-029 Counter widths: payload count WIDTH-AW bits, saturating; pointers clog2(DEPTH)+1 bits, wrap naturally.

Reset
REQ-030 reset=1: FSM IDLE, all FIFOs empty, pointers/counters 0, data_out 0, valid_out 0, busy 0, error 0, drop 0.
REQ-031 reset mid-packet discards partial packet; first pkt_valid after reset release is treated as header.

Structure
REQ-032 Shared package router_pkg holds FSM state enum, header field helpers, AW function.
REQ-033 One sub-module router_nport_fifo (WIDTH, DEPTH, flush input), instantiated NPORTS times via generate.

Verification
REQ-034 NPORTS=3: header addr=1 len=2, two payload, correct parity -> port 1 gets 4 words, valid_out=3'b010, error 0.
REQ-035 Bad parity word (XOR^1) -> CHECK cycle then error=1, held until next header accepted.
REQ-036 NPORTS=3, addr=3 -> drop pulse 1 cycle, no FIFO written, busy 0 throughout.
REQ-037 DEPTH=4, len=6, no reads -> busy rises after 4th write; read_enb pulses drain, busy falls, packet completes intact.
REQ-038 Packet to port 0, never read -> valid_out[0] drops TIMEOUT+1 cycles after first word lands.
REQ-039 Second packet to non-empty port 2 -> WAIT_EMPTY, busy 1 until port 2 drained, then header written.
